// File: rtl/router_fifo_reader.sv
// Drains a router_fifo and re-frames packets (sop header, payload, eop parity); FIFO byte to vld_out in 2 cycles, 1 byte/cycle.
// Honours ready_in through a 2-entry skid buffer, and a long client stall flushes the FIFO; `PARITY_CHECK_EN adds parity_err.
module router_fifo_reader #(
  parameter int DW          = 8,
  parameter int TIMEOUT_CYC = 30
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_data,
  output logic          fifo_rd_en,
  output logic          soft_reset,
  output logic          vld_out,
  input  logic          ready_in,
  output logic [DW-1:0] data_out,
  output logic          sop,
  output logic          eop,
`ifdef PARITY_CHECK_EN
  output logic          parity_err,
`endif
  output logic          busy
);

  localparam int LW = DW - 2;
  localparam int SW = $clog2(TIMEOUT_CYC) + 1;

  typedef enum logic [1:0] {IDLE, PAYLOAD, PARITY} state_t;

  state_t        state, state_nxt;
  logic [LW-1:0] len, len_nxt;
  logic          inflight;
  logic          run;
  logic [1:0]    occ;
  logic [DW-1:0] dat0, dat1;
  logic          sop0, sop1, eop0, eop1;
  logic [SW-1:0] stall_cnt;
  logic          pop, cap, stalled, flush, wr0;
  logic          cap_sop, cap_eop;

  assign vld_out    = (occ != 2'd0);
  assign data_out   = dat0;
  assign sop        = vld_out & sop0;
  assign eop        = vld_out & eop0;
  assign busy       = (state != IDLE);
  assign pop        = vld_out & ready_in;
  assign stalled    = vld_out & ~ready_in;
  assign flush      = stalled & (stall_cnt == SW'(TIMEOUT_CYC - 1));
  assign soft_reset = flush;
  assign cap        = inflight & ~flush;
  // A capture lands in the head slot when the buffer is empty after this cycle's pop.
  assign wr0        = (occ == 2'd0) | ((occ == 2'd1) & pop);

  // Credit check: never request a byte that would not fit once it arrives.
  assign fifo_rd_en = run & ~fifo_empty & ~flush &
                      (({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

  always_comb begin
    state_nxt = state;
    len_nxt   = len;
    cap_sop   = 1'b0;
    cap_eop   = 1'b0;
    if (flush) begin
      state_nxt = IDLE;
    end else if (cap) begin
      case (state)
        IDLE: begin
          cap_sop   = 1'b1;
          len_nxt   = fifo_data[DW-1:2];
          state_nxt = (fifo_data[DW-1:2] == '0) ? PARITY : PAYLOAD;
        end
        PAYLOAD: begin
          len_nxt = len - LW'(1);
          if (len == LW'(1)) state_nxt = PARITY;
        end
        PARITY: begin
          cap_eop   = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      len       <= '0;
      inflight  <= 1'b0;
      run       <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state    <= state_nxt;
      len      <= len_nxt;
      inflight <= fifo_rd_en;
      run      <= 1'b1;
      if (flush || !stalled) stall_cnt <= '0;
      else                   stall_cnt <= stall_cnt + SW'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      occ  <= 2'd0;
      dat0 <= '0;
      dat1 <= '0;
      sop0 <= 1'b0;
      sop1 <= 1'b0;
      eop0 <= 1'b0;
      eop1 <= 1'b0;
    end else if (flush) begin
      occ <= 2'd0;
    end else begin
      occ <= occ + {1'b0, cap} - {1'b0, pop};
      if (pop) begin
        dat0 <= dat1;
        sop0 <= sop1;
        eop0 <= eop1;
      end
      if (cap && wr0) begin
        dat0 <= fifo_data;
        sop0 <= cap_sop;
        eop0 <= cap_eop;
      end
      if (cap && !wr0) begin
        dat1 <= fifo_data;
        sop1 <= cap_sop;
        eop1 <= cap_eop;
      end
    end
  end

`ifdef PARITY_CHECK_EN
  logic [DW-1:0] xacc, xacc_nxt;
  logic          cap_perr, perr0, perr1;

  always_comb begin
    xacc_nxt = xacc;
    cap_perr = 1'b0;
    if (cap) begin
      case (state)
        IDLE:    xacc_nxt = fifo_data;
        PAYLOAD: xacc_nxt = xacc ^ fifo_data;
        PARITY:  cap_perr = (fifo_data != xacc);
        default: xacc_nxt = xacc;
      endcase
    end
  end

  // The mismatch flag rides with its byte so it fires on the eop transfer, not on capture.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      xacc  <= '0;
      perr0 <= 1'b0;
      perr1 <= 1'b0;
    end else begin
      xacc <= xacc_nxt;
      if (!flush) begin
        if (pop)          perr0 <= perr1;
        if (cap && wr0)   perr0 <= cap_perr;
        if (cap && !wr0)  perr1 <= cap_perr;
      end
    end
  end

  assign parity_err = pop & eop0 & perr0;
`endif

endmodule

// File: tb/tb_router_fifo_reader.sv
// Directed bench for router_fifo_reader with a behavioural router_fifo model on the read side.
module tb_router_fifo_reader;

  logic       clock = 1'b0;
  logic       resetn = 1'b1;
  logic       ready_in = 1'b1;
  logic [7:0] fifo_data = 8'd0;
  logic       fifo_empty;
  logic       fifo_rd_en, soft_reset, vld_out, sop, eop, busy;
  logic [7:0] data_out;
`ifdef PARITY_CHECK_EN
  logic       parity_err;
`endif

  int checks = 0;
  int errors = 0;

  router_fifo_reader #(.DW(8), .TIMEOUT_CYC(30)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .soft_reset (soft_reset),
    .vld_out    (vld_out),
    .ready_in   (ready_in),
    .data_out   (data_out),
    .sop        (sop),
    .eop        (eop),
`ifdef PARITY_CHECK_EN
    .parity_err (parity_err),
`endif
    .busy       (busy)
  );

  always #5 clock = ~clock;

  // Router FIFO model: registered read data, soft_reset/reset discard contents.
  logic [7:0] fmem [0:255];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clock) begin
    if (!resetn || soft_reset) rd_ptr <= wr_ptr;
    else if (fifo_rd_en && !fifo_empty) begin
      fifo_data <= fmem[rd_ptr];
      rd_ptr    <= rd_ptr + 8'd1;
    end
  end

  task automatic push(input logic [7:0] b);
    fmem[wr_ptr] = b;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  // Beat recorder shared by the scenarios; comparisons stay in the scenario tasks.
  logic [7:0] got_dat [0:15];
  logic       got_sop [0:15];
  logic       got_eop [0:15];
  logic       got_perr[0:15];
  int         got_cyc [0:15];
  int         got_n, first_rd, rd_viol, perr_stray;

  task automatic collect(input int ncyc, input int s0, input int slen);
    got_n = 0; first_rd = -1; rd_viol = 0; perr_stray = 0;
    for (int i = 0; i < 16; i++) begin
      got_dat[i] = 8'h00; got_sop[i] = 1'b0; got_eop[i] = 1'b0;
      got_perr[i] = 1'b0; got_cyc[i] = -1;
    end
    for (int c = 0; c < ncyc; c++) begin
      ready_in = !(c >= s0 && c < s0 + slen);
      #1;
      if (fifo_rd_en && first_rd < 0) first_rd = c;
      if (c > s0 && c < s0 + slen && fifo_rd_en) rd_viol++;
      if (vld_out && ready_in && got_n < 16) begin
        got_dat[got_n] = data_out;
        got_sop[got_n] = sop;
        got_eop[got_n] = eop;
        got_cyc[got_n] = c;
`ifdef PARITY_CHECK_EN
        got_perr[got_n] = parity_err;
`endif
        got_n++;
      end
`ifdef PARITY_CHECK_EN
      if (parity_err && !(vld_out && ready_in && eop)) perr_stray++;
`endif
      @(negedge clock);
    end
    ready_in = 1'b1;
  endtask

  task automatic test_reset();
    int bad;
    resetn = 1'b1; ready_in = 1'b1;
    #1 resetn = 1'b0;
    #2;
    checks++;
    if ({vld_out, fifo_rd_en, soft_reset, sop, eop, busy, data_out} !== 14'd0) begin
      errors++; $display("FAIL reset_init outputs=%b required 0", {vld_out, fifo_rd_en, soft_reset, sop, eop, busy, data_out});
    end
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    push(8'h11); push(8'hA1); push(8'hB2); push(8'hC3); push(8'hD4); push(8'h15);
    ready_in = 1'b0;
    repeat (4) @(negedge clock);
    #1;
    checks++;
    if ({vld_out, busy} !== 2'b11) begin
      errors++; $display("FAIL reset_prerun vld_busy=%b required 11", {vld_out, busy});
    end
    #1 resetn = 1'b0;
    #1;
    checks++;
    if ({vld_out, fifo_rd_en, soft_reset, sop, eop, busy, data_out} !== 14'd0) begin
      errors++; $display("FAIL reset_async outputs=%b required 0", {vld_out, fifo_rd_en, soft_reset, sop, eop, busy, data_out});
    end
    @(negedge clock); @(negedge clock);
    resetn = 1'b1; ready_in = 1'b1;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (vld_out || fifo_rd_en) bad++;
      @(negedge clock);
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL reset_release cycles_with_activity=%0d required 0", bad);
    end
  endtask

  task automatic test_basic();
    logic [7:0] pk [0:5];
    pk = '{8'h11, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h15};
    @(negedge clock);
    for (int i = 0; i < 6; i++) push(pk[i]);
    collect(12, 0, 0);
    checks++;
    if (first_rd !== 0) begin errors++; $display("FAIL basic_first_rd got=%0d required 0", first_rd); end
    checks++;
    if (got_n !== 6) begin errors++; $display("FAIL basic_beats got=%0d required 6", got_n); end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if ({got_dat[k], got_sop[k], got_eop[k]} !== {pk[k], k == 0, k == 5} || got_cyc[k] !== 2 + k) begin
        errors++;
        $display("FAIL basic_beat%0d got=%h sop=%b eop=%b cyc=%0d required %h %b %b %0d",
                 k, got_dat[k], got_sop[k], got_eop[k], got_cyc[k], pk[k], k == 0, k == 5, 2 + k);
      end
    end
    #1;
    checks++;
    if ({vld_out, busy} !== 2'b00) begin errors++; $display("FAIL basic_idle vld_busy=%b required 00", {vld_out, busy}); end
  endtask

  task automatic test_stall();
    logic [7:0] pk [0:5];
    pk = '{8'h11, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h15};
    @(negedge clock);
    for (int i = 0; i < 6; i++) push(pk[i]);
    collect(20, 4, 5);
    checks++;
    if (got_n !== 6) begin errors++; $display("FAIL stall_beats got=%0d required 6", got_n); end
    checks++;
    if (rd_viol !== 0) begin errors++; $display("FAIL stall_rd_en cycles_reading=%0d required 0", rd_viol); end
    checks++;
    if (got_cyc[2] !== 9) begin errors++; $display("FAIL stall_resume cyc=%0d required 9", got_cyc[2]); end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if ({got_dat[k], got_sop[k], got_eop[k]} !== {pk[k], k == 0, k == 5}) begin
        errors++;
        $display("FAIL stall_beat%0d got=%h sop=%b eop=%b required %h %b %b",
                 k, got_dat[k], got_sop[k], got_eop[k], pk[k], k == 0, k == 5);
      end
    end
  endtask

  task automatic test_timeout();
    int stall = 0;
    int pulse_at = 0;
    @(negedge clock);
    push(8'h11); push(8'hA1); push(8'hB2); push(8'hC3); push(8'hD4); push(8'h15);
    for (int c = 0; c < 60; c++) begin
      ready_in = 1'b0;
      #1;
      if (vld_out && !ready_in) stall++;
      if (soft_reset) begin
        pulse_at = stall;
        checks++;
        if ({busy, fifo_rd_en} !== 2'b10) begin
          errors++; $display("FAIL timeout_flush_cycle busy_rd=%b required 10", {busy, fifo_rd_en});
        end
        break;
      end
      @(negedge clock);
    end
    checks++;
    if (pulse_at !== 30) begin errors++; $display("FAIL timeout_pulse stall_cycle=%0d required 30", pulse_at); end
    @(negedge clock);
    #1;
    checks++;
    if ({vld_out, busy, soft_reset} !== 3'b000) begin
      errors++; $display("FAIL timeout_after vld_busy_srst=%b required 000", {vld_out, busy, soft_reset});
    end
    @(negedge clock);
    push(8'h02); push(8'h02);
    collect(8, 0, 0);
    checks++;
    if (got_n !== 2) begin errors++; $display("FAIL timeout_next_beats got=%0d required 2", got_n); end
    checks++;
    if ({got_dat[0], got_sop[0], got_eop[0], got_dat[1], got_sop[1], got_eop[1]} !== {8'h02, 2'b10, 8'h02, 2'b01}) begin
      errors++; $display("FAIL timeout_next_hdr got=%h/%b%b %h/%b%b required 02/10 02/01",
                         got_dat[0], got_sop[0], got_eop[0], got_dat[1], got_sop[1], got_eop[1]);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pk [0:4];
    logic       xs [0:4];
    logic       xe [0:4];
    pk = '{8'h00, 8'h00, 8'h05, 8'h5A, 8'h5F};
    xs = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    xe = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    @(negedge clock);
    for (int i = 0; i < 5; i++) push(pk[i]);
    collect(12, 0, 0);
    checks++;
    if (got_n !== 5) begin errors++; $display("FAIL b2b_beats got=%0d required 5", got_n); end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({got_dat[k], got_sop[k], got_eop[k]} !== {pk[k], xs[k], xe[k]} || got_cyc[k] !== 2 + k) begin
        errors++;
        $display("FAIL b2b_beat%0d got=%h sop=%b eop=%b cyc=%0d required %h %b %b %0d",
                 k, got_dat[k], got_sop[k], got_eop[k], got_cyc[k], pk[k], xs[k], xe[k], 2 + k);
      end
    end
  endtask

`ifdef PARITY_CHECK_EN
  task automatic test_parity();
    int flagged;
    @(negedge clock);
    push(8'h11); push(8'hA1); push(8'hB2); push(8'hC3); push(8'hD4); push(8'h15);
    collect(12, 0, 0);
    flagged = 0;
    for (int k = 0; k < 6; k++) if (got_perr[k]) flagged++;
    checks++;
    if (flagged + perr_stray !== 0) begin errors++; $display("FAIL parity_good pulses=%0d required 0", flagged + perr_stray); end
    @(negedge clock);
    push(8'h11); push(8'hA1); push(8'hB2); push(8'hC3); push(8'hD4); push(8'h14);
    collect(12, 0, 0);
    flagged = 0;
    for (int k = 0; k < 5; k++) if (got_perr[k]) flagged++;
    checks++;
    if (got_perr[5] !== 1'b1 || got_eop[5] !== 1'b1) begin
      errors++; $display("FAIL parity_bad_eop perr=%b eop=%b required 1 1", got_perr[5], got_eop[5]);
    end
    checks++;
    if (flagged + perr_stray !== 0) begin errors++; $display("FAIL parity_bad_other pulses=%0d required 0", flagged + perr_stray); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_timeout();
    test_back_to_back();
`ifdef PARITY_CHECK_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
